int_src_scheduler: RTL and testbench

//  Shares the single active-high interrupt pin to the 3014 host among SRC_NUM 3A/frame event sources (2a grey, wb, ...).

---
 rtl/int_src_scheduler_pkg.sv | 27 ++
 rtl/int_src_scheduler_rr_arbiter.sv | 40 ++++
 rtl/int_src_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_int_src_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_src_scheduler_pkg.sv
// Shared types and elaboration helpers for the interrupt source scheduler.
//   state_e        : scheduler FSM encoding
//   log2()         : ceiling log2, minimum 1 (index/counter widths)
//   time_interval(): minimum pulse-start spacing in clk cycles
package int_sched_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_ACK = 2'd2,
      GAP      = 2'd3
   } state_e;

   // Bits needed to hold values 0..v-1, never less than 1.
   function automatic int unsigned log2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // ms * kHz gives cycles directly.
   function automatic int unsigned time_interval(input int unsigned ms, input int unsigned khz);
      return ms * khz;
   endfunction

endpackage

// File: rtl/int_src_scheduler_rr_arbiter.sv
// Round-robin request picker: first request at or after ptr_i, wrapping.
// Purely combinational; the parent registers the result.
//   req_i     : request vector
//   ptr_i     : highest-priority index this round
//   gnt_oh_c  : one-hot grant
//   gnt_idx_c : grant index
//   gnt_vld_c : any request present
module rr_arbiter
   import int_sched_pkg::*;
#(
   parameter int unsigned SRC_NUM = 4
) (
   input  logic [SRC_NUM-1:0]       req_i,
   input  logic [log2(SRC_NUM)-1:0] ptr_i,
   output logic [SRC_NUM-1:0]       gnt_oh_c,
   output logic [log2(SRC_NUM)-1:0] gnt_idx_c,
   output logic                     gnt_vld_c
);

   localparam int unsigned IDW = log2(SRC_NUM);

   int unsigned j;

   // Scan from the pointer; first hit wins.
   always_comb begin
      gnt_oh_c  = '0;
      gnt_idx_c = '0;
      gnt_vld_c = 1'b0;
      j         = 0;
      for (int unsigned k = 0; k < SRC_NUM; k++) begin
         j = (32'(ptr_i) + k) % SRC_NUM;
         if (!gnt_vld_c && req_i[IDW'(j)]) begin
            gnt_vld_c             = 1'b1;
            gnt_oh_c[IDW'(j)]     = 1'b1;
            gnt_idx_c             = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/int_src_scheduler.sv
// Shares one active-high host interrupt pin among SRC_NUM event sources.
// Latches per-source pending bits, grants one source per interrupt round-robin,
// drives a PULSE_CYCLES-wide pulse, waits for the host clear, then holds off
// until TIME_INTERVAL cycles have passed since the previous pulse start.
// Optional: `INT_ACK_TIMEOUT_EN adds an ack timeout (4*TIME_INTERVAL from pulse
// start) that force-clears the served pending bit and sets sticky o_ack_timeout.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   i_acquisition_start          acquisition running
//   i_stream_enable              stream on (active = both high)
//   iv_src_event/en/int_clear    per-source event pulse, enable, W1C clear
//   ov_int_pending               latched pending bits
//   ov_int_state/ov_int_src_id   one-hot / index of the served source
//   o_interrupt                  host interrupt pin
//   o_ack_timeout                sticky ack-timeout flag
module int_src_scheduler
   import int_sched_pkg::*;
#(
   parameter int unsigned SRC_NUM              = 4,
   parameter int unsigned INT_TIME_INTERVAL_MS = 50,
   parameter int unsigned CLK_FREQ_KHZ         = 55000,
   parameter int unsigned PULSE_CYCLES         = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_acquisition_start,
   input  logic                     i_stream_enable,
   input  logic [SRC_NUM-1:0]       iv_src_event,
   input  logic [SRC_NUM-1:0]       iv_src_en,
   input  logic [SRC_NUM-1:0]       iv_int_clear,
   output logic [SRC_NUM-1:0]       ov_int_pending,
   output logic [SRC_NUM-1:0]       ov_int_state,
   output logic [log2(SRC_NUM)-1:0] ov_int_src_id,
   output logic                     o_interrupt,
   output logic                     o_ack_timeout
);

   localparam int unsigned IDW           = log2(SRC_NUM);
   localparam int unsigned TIME_INTERVAL = time_interval(INT_TIME_INTERVAL_MS, CLK_FREQ_KHZ);
   localparam int unsigned CNT_W         = log2(TIME_INTERVAL + 1);
   localparam int unsigned PW            = log2(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] TI_CNT   = CNT_W'(TIME_INTERVAL);

   state_e               state_q, state_d;
   logic [SRC_NUM-1:0]   pend_q, pend_d;
   logic [SRC_NUM-1:0]   gstate_q, gstate_d;
   logic [IDW-1:0]       gid_q, gid_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic                 irq_q, irq_d;
   logic [CNT_W-1:0]     ivl_q, ivl_d;
   logic [PW-1:0]        pcnt_q, pcnt_d;

   logic                 active_c;
   logic                 grant_ok_c;
   logic                 do_grant_c;
   logic [SRC_NUM-1:0]   force_clr_c;
   logic [SRC_NUM-1:0]   gnt_oh_c;
   logic [IDW-1:0]       gnt_idx_c;
   logic                 gnt_vld_c;

`ifdef INT_ACK_TIMEOUT_EN
   localparam int unsigned TO_W        = log2(4 * TIME_INTERVAL + 1);
   localparam logic [TO_W-1:0] TO_LIM  = TO_W'(4 * TIME_INTERVAL);
   logic [TO_W-1:0]      tmo_q, tmo_d;
   logic                 to_flag_q, to_flag_d;
`endif

   assign active_c = i_acquisition_start & i_stream_enable;

   rr_arbiter #(.SRC_NUM(SRC_NUM)) u_rr_arbiter (
      .req_i     (pend_q & iv_src_en),
      .ptr_i     (ptr_q),
      .gnt_oh_c  (gnt_oh_c),
      .gnt_idx_c (gnt_idx_c),
      .gnt_vld_c (gnt_vld_c)
   );

   // Interval counter counts cycles since pulse start inclusive of that cycle,
   // so "== TIME_INTERVAL" lands the next pulse exactly TIME_INTERVAL later.
   assign grant_ok_c = active_c & gnt_vld_c & (ivl_q == TI_CNT);

   // Next-state, pending and output logic.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      gstate_d    = gstate_q;
      gid_d       = gid_q;
      ptr_d       = ptr_q;
      irq_d       = 1'b0;
      pcnt_d      = pcnt_q;
      ivl_d       = (ivl_q == TI_CNT) ? ivl_q : ivl_q + CNT_W'(1);
      do_grant_c  = 1'b0;
      force_clr_c = '0;
`ifdef INT_ACK_TIMEOUT_EN
      tmo_d       = (tmo_q == TO_LIM) ? tmo_q : tmo_q + TO_W'(1);
      to_flag_d   = to_flag_q;
`endif

      case (state_q)
         IDLE: begin
            if (grant_ok_c) do_grant_c = 1'b1;
         end
         PULSE: begin
            pcnt_d = pcnt_q + PW'(1);
            if (pcnt_q == PW'(PULSE_CYCLES - 1)) state_d = WAIT_ACK;
            else                                 irq_d   = 1'b1;
         end
         WAIT_ACK: begin
            if (!pend_q[gid_q]) begin
               state_d = GAP;
`ifdef INT_ACK_TIMEOUT_EN
            end else if (tmo_q == TO_LIM) begin
               force_clr_c[gid_q] = 1'b1;
               to_flag_d          = 1'b1;
               state_d            = GAP;
`endif
            end
         end
         GAP: begin
            // Falls through IDLE in the same cycle when a grant is ready.
            if (ivl_q == TI_CNT) begin
               if (grant_ok_c) do_grant_c = 1'b1;
               else            state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_grant_c) begin
         state_d  = PULSE;
         irq_d    = 1'b1;
         pcnt_d   = '0;
         ivl_d    = CNT_W'(1);
         gstate_d = gnt_oh_c;
         gid_d    = gnt_idx_c;
         ptr_d    = (gnt_idx_c == IDW'(SRC_NUM - 1)) ? '0 : gnt_idx_c + IDW'(1);
`ifdef INT_ACK_TIMEOUT_EN
         tmo_d    = TO_W'(1);
`endif
      end

      // Set beats host clear; timeout force-clear beats everything while active.
      for (int i = 0; i < int'(SRC_NUM); i++) begin
         if (!active_c)                          pend_d[i] = 1'b0;
         else if (force_clr_c[i])                pend_d[i] = 1'b0;
         else if (iv_src_event[i] & iv_src_en[i]) pend_d[i] = 1'b1;
         else if (iv_int_clear[i] | !iv_src_en[i]) pend_d[i] = 1'b0;
      end

      if (!active_c) begin
         state_d  = IDLE;
         irq_d    = 1'b0;
         gstate_d = '0;
         gid_d    = '0;
`ifdef INT_ACK_TIMEOUT_EN
         to_flag_d = 1'b0;
`endif
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         gstate_q <= '0;
         gid_q    <= '0;
         ptr_q    <= '0;
         irq_q    <= 1'b0;
         ivl_q    <= TI_CNT;
         pcnt_q   <= '0;
`ifdef INT_ACK_TIMEOUT_EN
         tmo_q     <= '0;
         to_flag_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         gstate_q <= gstate_d;
         gid_q    <= gid_d;
         ptr_q    <= ptr_d;
         irq_q    <= irq_d;
         ivl_q    <= ivl_d;
         pcnt_q   <= pcnt_d;
`ifdef INT_ACK_TIMEOUT_EN
         tmo_q     <= tmo_d;
         to_flag_q <= to_flag_d;
`endif
      end
   end

   assign ov_int_pending = pend_q;
   assign ov_int_state   = gstate_q;
   assign ov_int_src_id  = gid_q;
   assign o_interrupt    = irq_q;
`ifdef INT_ACK_TIMEOUT_EN
   assign o_ack_timeout  = to_flag_q;
`else
   assign o_ack_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_int_src_scheduler.sv
// Scoreboard bench for int_src_scheduler (TIME_INTERVAL = 100, 16-cycle pulse).
module tb_int_src_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_acquisition_start;
   logic       i_stream_enable;
   logic [3:0] iv_src_event;
   logic [3:0] iv_src_en;
   logic [3:0] iv_int_clear;
   logic [3:0] ov_int_pending;
   logic [3:0] ov_int_state;
   logic [1:0] ov_int_src_id;
   logic       o_interrupt;
   logic       o_ack_timeout;

   int_src_scheduler #(
      .SRC_NUM(4), .INT_TIME_INTERVAL_MS(1), .CLK_FREQ_KHZ(100), .PULSE_CYCLES(16)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i_acquisition_start (i_acquisition_start),
      .i_stream_enable     (i_stream_enable),
      .iv_src_event        (iv_src_event),
      .iv_src_en           (iv_src_en),
      .iv_int_clear        (iv_int_clear),
      .ov_int_pending      (ov_int_pending),
      .ov_int_state        (ov_int_state),
      .ov_int_src_id       (ov_int_src_id),
      .o_interrupt         (o_interrupt),
      .o_ack_timeout       (o_ack_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         start;
      logic [3:0] st;
      logic [1:0] id;
      int         width;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int s, input logic [3:0] st, input logic [1:0] id, input int w);
      exp_t e;
      e.start = s; e.st = st; e.id = id; e.width = w;
      exp_q.push_back(e);
   endtask

   // Monitor: each rising edge of o_interrupt consumes one expected grant.
   exp_t cur;
   logic irq_prev = 1'b0;
   logic have     = 1'b0;
   int   hi_cnt   = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_interrupt && !irq_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_irq", 1, 0);
               have = 1'b0;
            end else begin
               cur = exp_q.pop_front();
               have = 1'b1;
               check("irq_start_cycle", cyc, cur.start);
               check("irq_state", int'(ov_int_state), int'(cur.st));
               check("irq_src_id", int'(ov_int_src_id), int'(cur.id));
            end
            hi_cnt = 1;
         end else if (o_interrupt) begin
            hi_cnt++;
         end
         if (!o_interrupt && irq_prev && have) begin
            check("irq_width", hi_cnt, cur.width);
            have = 1'b0;
         end
      end
      irq_prev = o_interrupt;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic ev(input logic [3:0] m);
      iv_src_event = m; tick(1); iv_src_event = '0;
   endtask

   task automatic clr(input logic [3:0] m);
      iv_int_clear = m; tick(1); iv_int_clear = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
   endtask

   int t;

   initial begin
      rst_n = 1'b0;
      i_acquisition_start = 1'b1;
      i_stream_enable     = 1'b1;
      iv_src_event = '0;
      iv_src_en    = 4'hF;
      iv_int_clear = '0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      check("rst_pending", int'(ov_int_pending), 0);
      check("rst_state",   int'(ov_int_state), 0);
      check("rst_src_id",  int'(ov_int_src_id), 0);
      check("rst_irq",     int'(o_interrupt), 0);
      check("rst_ack_to",  int'(o_ack_timeout), 0);

      // Single source, immediate grant, host clear.
      t = cyc;
      push(t + 2, 4'b0001, 2'd0, 16);
      ev(4'b0001);
      wait_until(t + 19);
      check("t1_pend_hold", int'(ov_int_pending), 1);
      wait_until(t + 20);
      clr(4'b0001);
      check("t1_pend_clr", int'(ov_int_pending), 0);
      wait_until(t + 130);

      // Two simultaneous events: src0 then src2 exactly 100 cycles later.
      do_reset();
      t = cyc;
      push(t + 2,   4'b0001, 2'd0, 16);
      push(t + 102, 4'b0100, 2'd2, 16);
      ev(4'b0101);
      check("t2_pend_both", int'(ov_int_pending), 5);
      wait_until(t + 20);
      clr(4'b0001);
      check("t2_pend_src2", int'(ov_int_pending), 4);
      wait_until(t + 125);
      clr(4'b0100);
      check("t2_pend_none", int'(ov_int_pending), 0);
      wait_until(t + 210);

      // Pointer at 3 wraps to src0 first.
      t = cyc;
      push(t + 2,   4'b0001, 2'd0, 16);
      push(t + 102, 4'b0100, 2'd2, 16);
      ev(4'b0101);
      wait_until(t + 20);
      clr(4'b0001);
      wait_until(t + 125);
      clr(4'b0100);
      wait_until(t + 210);

      // Set beats clear; disabling the served source releases WAIT_ACK.
      t = cyc;
      push(t + 2, 4'b0010, 2'd1, 16);
      iv_src_event = 4'b0010; iv_int_clear = 4'b0010;
      tick(1);
      iv_src_event = '0; iv_int_clear = '0;
      check("t4_set_wins", int'(ov_int_pending), 2);
      wait_until(t + 20);
      iv_src_en = 4'b1101;
      tick(2);
      check("t4_disable_clr", int'(ov_int_pending), 0);
      iv_src_en = 4'hF;
      push(t + 102, 4'b0001, 2'd0, 16);
      ev(4'b0001);
      wait_until(t + 125);
      clr(4'b0001);
      wait_until(t + 210);

      // Stream off mid-pulse truncates it; spacing is still held afterwards.
      t = cyc;
      push(t + 2, 4'b0001, 2'd0, 5);
      ev(4'b0001);
      wait_until(t + 6);
      i_stream_enable = 1'b0;
      tick(1);
      check("t5_irq_off", int'(o_interrupt), 0);
      check("t5_pend_off", int'(ov_int_pending), 0);
      check("t5_state_off", int'(ov_int_state), 0);
      check("t5_id_off", int'(ov_int_src_id), 0);
      wait_until(t + 10);
      ev(4'b0001);
      check("t5_ignored", int'(ov_int_pending), 0);
      wait_until(t + 20);
      i_stream_enable = 1'b1;
      push(t + 102, 4'b0010, 2'd1, 16);
      ev(4'b0010);
      check("t5_pend_again", int'(ov_int_pending), 2);
      wait_until(t + 125);
      clr(4'b0010);
      wait_until(t + 210);

`ifdef INT_ACK_TIMEOUT_EN
      // No host clear: timeout 400 cycles after pulse start.
      t = cyc;
      push(t + 2, 4'b1000, 2'd3, 16);
      ev(4'b1000);
      wait_until(t + 401);
      check("t6_pend_before", int'(ov_int_pending), 8);
      check("t6_flag_before", int'(o_ack_timeout), 0);
      tick(1);
      check("t6_pend_forced", int'(ov_int_pending), 0);
      check("t6_flag_set", int'(o_ack_timeout), 1);
      wait_until(t + 450);
      check("t6_flag_sticky", int'(o_ack_timeout), 1);
      i_stream_enable = 1'b0;
      tick(1);
      check("t6_flag_clr", int'(o_ack_timeout), 0);
      i_stream_enable = 1'b1;
`else
      check("ack_to_tied", int'(o_ack_timeout), 0);
`endif

      tick(5);
      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
